// File: rtl/serial_add_ctrl_if.sv
// Handshake/operand bundle for serial_add_ctrl.
// With SERIAL_ADD_OVF_EN defined, the bundle also carries the ovf result flag.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, A, B, Cin,
`ifdef SERIAL_ADD_OVF_EN
    input  ovf,
`endif
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, Cin,
`ifdef SERIAL_ADD_OVF_EN
    output ovf,
`endif
    output busy, done, Sum, Cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Serial adder: one 2-bit ripple-carry slice reused over WIDTH/2 cycles.
// Optional two's-complement overflow flag (ovf) when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, part_q, sum_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [CntW-1:0]  cnt_q;

  // Two gate-level full adders chained into the shared 2-bit slice.
  logic       p0, p1, c_mid, slice_cout;
  logic [1:0] slice_sum;

  assign p0           = a_q[0] ^ b_q[0];
  assign slice_sum[0] = p0 ^ carry_q;
  assign c_mid        = (a_q[0] & b_q[0]) | (p0 & carry_q);
  assign p1           = a_q[1] ^ b_q[1];
  assign slice_sum[1] = p1 ^ c_mid;
  assign slice_cout   = (a_q[1] & b_q[1]) | (p1 & c_mid);

  logic [WIDTH-1:0] part_next;
  generate
    if (WIDTH > 2) begin : g_wide
      assign part_next = {slice_sum, part_q[WIDTH-1:2]};
    end else begin : g_narrow
      assign part_next = slice_sum;
    end
  endgenerate

  logic last;
  assign last = (cnt_q == CntW'(N - 1));

`ifdef SERIAL_ADD_OVF_EN
  // On the last slice, a_q[1]/b_q[1] hold the original operand sign bits.
  logic ovf_q, ovf_next;
  assign ovf_next = (a_q[1] == b_q[1]) && (part_next[WIDTH-1] != a_q[1]);
  assign bus.ovf  = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        // DONE also samples start so that a held start is accepted every N+1 cycles.
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= bus.Cin;
            part_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q     <= a_q >> 2;
          b_q     <= b_q >> 2;
          part_q  <= part_next;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + CntW'(1);
          if (last) begin
            sum_q   <= part_next;
            cout_q  <= slice_cout;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_next;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_serial_add_ctrl;
  localparam int unsigned W = 8;
  localparam int unsigned N = W / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];
  logic [W-1:0] prev_sum;

  // One accepted addition: checks latency, hold of Sum, result and the single done pulse.
  task automatic run_add(input vec_t v);
    int  cyc;
    bit  hold_bad;
    bus.start = 1'b1; bus.A = v.a; bus.B = v.b; bus.Cin = v.cin;
    step();
    bus.start = 1'b0; bus.A = ~v.a; bus.B = ~v.b; bus.Cin = ~v.cin;
    chk("busy after accept", bus.busy, 1);
    cyc = 0;
    hold_bad = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.Sum !== prev_sum) hold_bad = 1;
      step();
      cyc++;
    end
    chk("latency", cyc, N);
    chk("sum hold", hold_bad, 0);
    chk("busy at done", bus.busy, 0);
    chk("sum", bus.Sum, v.sum);
    chk("cout", bus.Cout, v.cout);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", bus.ovf, v.ovf);
`endif
    step();
    chk("done one cycle", bus.done, 0);
    chk("sum held after done", bus.Sum, v.sum);
    prev_sum = v.sum;
  endtask

  // Reference model state: cycles left in the current addition and its pending result.
  int           m_left;
  logic [W:0]   m_pend;
  logic [W-1:0] m_sum, m_a, m_b;
  logic         m_cout, m_done, m_ovf, m_pa, m_pb;

  initial begin
    int dones, last_done_sum;
    bit done_at[16];
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};

    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    #12;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset sum", bus.Sum, 0);
    chk("reset cout", bus.Cout, 0);
    rst_n = 1'b1;
    step();
    prev_sum = '0;

    for (int i = 0; i < 8; i++) run_add(vecs[i]);

    // Start while busy is ignored.
    bus.start = 1'b1; bus.A = 8'h10; bus.B = 8'h20; bus.Cin = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.A = 8'h01; bus.B = 8'h01;
    step();
    bus.start = 1'b0;
    dones = 0;
    last_done_sum = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done) begin dones++; last_done_sum = int'(bus.Sum); end
      step();
    end
    chk("ignored start dones", dones, 1);
    chk("ignored start sum", last_done_sum, 32'h30);

    // Reset asserted mid-run aborts without a done pulse.
    bus.start = 1'b1; bus.A = 8'h40; bus.B = 8'h40;
    step();
    bus.start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort sum", bus.Sum, 0);
    chk("abort cout", bus.Cout, 0);
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done) dones++;
      step();
    end
    chk("abort no done", dones, 0);
    prev_sum = '0;
    run_add(vecs[7]);

    // Start held high for 15 edges: acceptances every N+1 cycles.
    bus.start = 1'b1; bus.A = 8'h01; bus.B = 8'h02; bus.Cin = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      done_at[k] = bus.done;
    end
    bus.start = 1'b0;
    step();
    done_at[15] = bus.done;
    for (int k = 0; k < 16; k++) chk($sformatf("held done[%0d]", k), done_at[k], (k % 5) == 4);
    chk("held sum", bus.Sum, 8'h03);
    step();
    chk("held idle", bus.busy, 0);

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    m_left = 0; m_sum = '0; m_cout = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
    m_pa = 1'b0; m_pb = 1'b0; m_pend = '0;
    step();
    for (int k = 0; k < 400; k++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.A = W'($urandom); bus.B = W'($urandom); bus.Cin = 1'($urandom);
      m_a = bus.A; m_b = bus.B;
      begin
        logic st, ci;
        st = bus.start; ci = bus.Cin;
        step();
        m_done = 1'b0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_sum  = m_pend[W-1:0];
            m_cout = m_pend[W];
            m_ovf  = (m_pa == m_pb) && (m_pend[W-1] != m_pa);
            m_done = 1'b1;
          end
        end else if (st) begin
          m_pend = {1'b0, m_a} + {1'b0, m_b} + (W+1)'(ci);
          m_pa   = m_a[W-1];
          m_pb   = m_b[W-1];
          m_left = N;
        end
      end
      chk("rand busy", bus.busy, m_left > 0);
      chk("rand done", bus.done, m_done);
      chk("rand sum", bus.Sum, m_sum);
      chk("rand cout", bus.Cout, m_cout);
`ifdef SERIAL_ADD_OVF_EN
      chk("rand ovf", bus.ovf, m_ovf);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
